// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   if_state_t  : request tracker state (IDLE / WAIT / DISCARD)
//   if_entry_t  : prefetch queue entry {pc, inst} at the default word width
//   IF_*_DEF    : default constants for PC step and redirect offset shift
package if_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // nothing outstanding
    WAIT    = 2'd1,  // one live request outstanding
    DISCARD = 2'd2   // one stale request outstanding, its data is dropped
  } if_state_t;

  localparam int IF_WORD_LEN_DEF     = 16;
  localparam int IF_PC_STEP_DEF      = 4;
  localparam int IF_OFFSET_SHIFT_DEF = 1;

  typedef struct packed {
    logic [IF_WORD_LEN_DEF-1:0] pc;
    logic [IF_WORD_LEN_DEF-1:0] inst;
  } if_entry_t;

endpackage

// File: rtl/if_prefetch_queue.sv
// Synchronous FIFO holding fetched {pc, inst} entries.
// Ports:
//   clk, rst            : clock, async active-high reset
//   i_push, i_push_data : write an entry (ignored when full)
//   i_pop               : remove the head (ignored when empty)
//   i_flush             : drop all entries; wins over push/pop
//   o_head              : head entry (stale contents when empty)
//   o_empty             : queue holds nothing
//   o_count             : current occupancy 0..DEPTH
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = if_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  entry_t                   i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output entry_t                   o_head,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  logic w_push;
  logic w_pop;

  assign w_push = i_push && (r_count != (AW+1)'(DEPTH));
  assign w_pop  = i_pop  && (r_count != '0);

  // Storage needs no reset: contents are only observed through count.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_push_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit_pq.sv
// Decoupled instruction-fetch stage with a prefetch queue.
// Issues sequential requests (one outstanding at most), buffers responses
// with their PCs, hands the head to decode unless frozen. Branch/jump
// redirects flush the queue and mark any outstanding request stale.
// Optional feature macro: IF_MISALIGN_TRAP_EN -- a misaligned redirect target
// raises a sticky fetch_fault and stops fetching; otherwise the target's low
// bits are cleared and fetch_fault is tied low.
// Ports:
//   clk, rst                        : clock, async active-high reset
//   br_taken, br_pc, br_offset      : branch redirect (highest priority)
//   jump_en, jump_addr              : jump redirect
//   freeze                          : decode stall, head is held
//   imem_req, imem_addr             : memory request
//   imem_rvalid, imem_rdata         : memory response
//   inst_valid, inst, inst_pc       : queue head to decode (0 when empty)
//   fetch_fault                     : misaligned-redirect trap
module fetch_unit_pq
  import if_pkg::*;
#(
  parameter int WORD_LEN     = 16,
  parameter int QUEUE_DEPTH  = 4,
  parameter int PC_STEP      = IF_PC_STEP_DEF,
  parameter int OFFSET_SHIFT = IF_OFFSET_SHIFT_DEF,
  parameter int RESET_PC     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_pc,
  input  logic [WORD_LEN-1:0] br_offset,
  input  logic                jump_en,
  input  logic [WORD_LEN-1:0] jump_addr,
  input  logic                freeze,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_rvalid,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic                inst_valid,
  output logic [WORD_LEN-1:0] inst,
  output logic [WORD_LEN-1:0] inst_pc,
  output logic                fetch_fault
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [WORD_LEN-1:0] ALIGN_MASK = WORD_LEN'(PC_STEP - 1);

  typedef struct packed {
    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] inst;
  } entry_t;

  if_state_t           r_state;
  logic [WORD_LEN-1:0] r_fetch_pc;
  logic [WORD_LEN-1:0] r_req_pc;   // address of the outstanding request
  logic                r_fault;

  logic                w_redir;
  logic [WORD_LEN-1:0] w_target_raw;
  logic [WORD_LEN-1:0] w_target;
  logic                w_trap;
  logic                w_req;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic [AW:0]         w_count;
  entry_t              w_head;
  entry_t              w_push_data;

  // Redirect target; branch wins when both are asserted.
  assign w_redir      = br_taken || jump_en;
  assign w_target_raw = br_taken ? (br_pc + (br_offset << OFFSET_SHIFT))
                                 : (jump_addr << OFFSET_SHIFT);

`ifdef IF_MISALIGN_TRAP_EN
  assign w_target = w_target_raw;
  assign w_trap   = w_redir && ((w_target_raw & ALIGN_MASK) != '0);
`else
  assign w_target = w_target_raw & ~ALIGN_MASK;
  assign w_trap   = 1'b0;
`endif

  // Requesting only from IDLE with a free slot reserves space for the
  // response, so the queue can never overflow.
  assign w_req = !rst && (r_state == IDLE) && !w_redir && !r_fault &&
                 (w_count < (AW+1)'(QUEUE_DEPTH));

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;

  assign w_push      = (r_state == WAIT) && imem_rvalid && !w_redir;
  assign w_push_data = '{pc: r_req_pc, inst: imem_rdata};
  assign w_pop       = !w_empty && !freeze;

  if_prefetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (w_redir),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= WORD_LEN'(RESET_PC);
      r_req_pc   <= '0;
      r_fault    <= 1'b0;
    end else if (w_redir) begin
      r_fetch_pc <= w_target;
      if (w_trap) r_fault <= 1'b1;
      // Anything outstanding becomes stale; a response arriving this same
      // cycle is simply dropped.
      case (r_state)
        WAIT:    r_state <= imem_rvalid ? IDLE : DISCARD;
        DISCARD: r_state <= imem_rvalid ? IDLE : DISCARD;
        default: r_state <= IDLE;
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + WORD_LEN'(PC_STEP);
            r_state    <= WAIT;
          end
        end
        WAIT:    if (imem_rvalid) r_state <= IDLE;
        DISCARD: if (imem_rvalid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign inst_valid  = !w_empty;
  assign inst        = w_empty ? '0 : w_head.inst;
  assign inst_pc     = w_empty ? '0 : w_head.pc;
  assign fetch_fault = r_fault;

endmodule

// File: tb/tb_fetch_unit_pq.sv
// Directed bench for fetch_unit_pq with a variable-latency memory model.
// Memory returns inst = addr ^ 16'hBEEF.
module tb_fetch_unit_pq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_taken = 1'b0;
  logic [15:0] br_pc = '0;
  logic [15:0] br_offset = '0;
  logic        jump_en = 1'b0;
  logic [15:0] jump_addr = '0;
  logic        freeze = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        fetch_fault;

  int n_vec = 0;
  int n_err = 0;

  int          lat = 1;
  logic        m_pend;
  logic [15:0] m_addr;
  int          m_cnt;
  logic        seen80;

  fetch_unit_pq dut (
    .clk(clk), .rst(rst),
    .br_taken(br_taken), .br_pc(br_pc), .br_offset(br_offset),
    .jump_en(jump_en), .jump_addr(jump_addr), .freeze(freeze),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory: request seen at edge E answers in the cycle starting at E+lat-1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend      <= 1'b0;
      m_addr      <= '0;
      m_cnt       <= 0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      imem_rvalid <= 1'b0;
      if (m_pend) begin
        if (m_cnt == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= m_addr ^ 16'hBEEF;
          m_pend      <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (imem_req) begin
        if (imem_addr == 16'h0080) seen80 <= 1'b1;
        if (lat == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= imem_addr ^ 16'hBEEF;
        end else begin
          m_pend <= 1'b1;
          m_addr <= imem_addr;
          m_cnt  <= lat - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at a negedge with rst just released (cycle 0 of the new run).
  task automatic do_reset(input logic frz, input int l);
    @(negedge clk);
    rst = 1'b1; br_taken = 0; jump_en = 0; freeze = frz; lat = l;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (inst_valid) break;
      @(negedge clk); #1;
    end
    if (!inst_valid) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    seen80 = 1'b0;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req",   imem_req,    0);
    chk("rst_valid", inst_valid,  0);
    chk("rst_inst",  inst,        0);
    chk("rst_pc",    inst_pc,     0);
    chk("rst_fault", fetch_fault, 0);

    // Sequential fetch, L=1
    rst = 1'b0; #1;
    chk("seq_c0_req",  imem_req,  1);
    chk("seq_c0_addr", imem_addr, 16'h0000);
    @(negedge clk); #1;
    chk("seq_c1_req",   imem_req,   0);
    chk("seq_c1_valid", inst_valid, 0);
    @(negedge clk); #1;
    chk("seq_c2_valid", inst_valid, 1);
    chk("seq_c2_pc",    inst_pc,    16'h0000);
    chk("seq_c2_inst",  inst,       16'hBEEF);
    chk("seq_c2_addr",  imem_addr,  16'h0004);
    @(negedge clk); #1;
    chk("seq_c3_valid", inst_valid, 0);
    @(negedge clk); #1;
    chk("seq_c4_pc",   inst_pc, 16'h0004);
    chk("seq_c4_inst", inst,    16'hBEEB);
    repeat (2) @(negedge clk); #1;
    chk("seq_c6_pc",   inst_pc, 16'h0008);
    chk("seq_c6_inst", inst,    16'hBEE7);

    // Freeze: queue fills to 4, head held, requests stop
    do_reset(1'b1, 1);
    repeat (12) @(negedge clk); #1;
    chk("frz_valid", inst_valid, 1);
    chk("frz_pc",    inst_pc,    16'h0000);
    chk("frz_req",   imem_req,   0);
    @(negedge clk); #1;
    chk("frz_hold_pc", inst_pc, 16'h0000);
    freeze = 1'b0; #1;
    chk("rel_pc0", inst_pc, 16'h0000);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      chk("rel_valid", inst_valid, 1);
      chk("rel_pc",    inst_pc,    16'(4 * k));
    end

    // Branch while 0x14 outstanding, L=3
    do_reset(1'b0, 3);
    for (int i = 0; i < 100; i++) begin
      if (imem_req && imem_addr == 16'h0014) break;
      @(negedge clk); #1;
    end
    chk("br_saw_req14", imem_addr, 16'h0014);
    @(negedge clk);
    br_taken = 1'b1; br_pc = 16'h0010; br_offset = 16'h0008; #1;
    chk("br_no_req", imem_req, 0);
    @(negedge clk);
    br_taken = 1'b0; #1;
    chk("br_flushed", inst_valid, 0);
    wait_valid("br_timeout");
    chk("br_pc",   inst_pc, 16'h0020);
    chk("br_inst", inst,    16'hBECF);

    // Branch and jump together: branch wins, 0x80 never requested
    do_reset(1'b0, 1);
    repeat (3) @(negedge clk);
    seen80 = 1'b0;
    br_taken = 1'b1; jump_en = 1'b1;
    br_pc = 16'h0030; br_offset = 16'h0002; jump_addr = 16'h0040; #1;
    chk("both_no_req", imem_req, 0);
    @(negedge clk);
    br_taken = 1'b0; jump_en = 1'b0; #1;
    wait_valid("both_timeout");
    chk("both_pc",   inst_pc, 16'h0034);
    chk("both_inst", inst,    16'hBEDB);
    repeat (6) @(negedge clk);
    chk("both_no80", seen80, 0);

    // Misaligned jump to 0x22
    do_reset(1'b0, 1);
    repeat (2) @(negedge clk);
    jump_en = 1'b1; jump_addr = 16'h0011;
    @(negedge clk);
    jump_en = 1'b0; #1;
`ifdef IF_MISALIGN_TRAP_EN
    for (int k = 0; k < 4; k++) begin
      chk("mis_fault", fetch_fault, 1);
      chk("mis_req",   imem_req,    0);
      chk("mis_valid", inst_valid,  0);
      @(negedge clk); #1;
    end
`else
    wait_valid("mis_timeout");
    chk("mis_pc",    inst_pc,     16'h0020);
    chk("mis_fault", fetch_fault, 0);
`endif

    // Reset during WAIT
    do_reset(1'b0, 3);
    chk("rw_c0_req", imem_req, 1);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("rw_req",   imem_req,    0);
    chk("rw_valid", inst_valid,  0);
    chk("rw_inst",  inst,        0);
    chk("rw_pc",    inst_pc,     0);
    chk("rw_fault", fetch_fault, 0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("rw_rel_req",  imem_req,  1);
    chk("rw_rel_addr", imem_addr, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit_pq.md
# fetch_unit_pq

Parametrised instruction-fetch stage: a decoupled prefetch unit that issues sequential instruction-memory requests over a latency-tolerant request/response port, buffers returned instructions with their PCs in a small prefetch queue, and hands them to decode under a freeze/backpressure rule. Branch and jump redirects flush the queue and discard in-flight responses. It replaces the single-register, combinational-memory fetch stage at the front of the pipeline, with configurable word width, queue depth and PC step.

## Interface
- WORD_LEN, 16, width of PC, instruction and offsets
- QUEUE_DEPTH, 4, prefetch queue entries; power of two, ≥2
- PC_STEP, 4, PC increment per fetch; power of two
- OFFSET_SHIFT, 1, left shift applied to branch offset and jump address
- RESET_PC, 0, fetch PC after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- br_taken  in  1  branch redirect; highest priority
- br_pc  in  WORD_LEN  PC of the resolving branch
- br_offset  in  WORD_LEN  signed branch offset
- jump_en  in  1  jump redirect
- jump_addr  in  WORD_LEN  absolute jump address, pre-shift
- freeze  in  1  decode stall; head entry is held
- imem_req  out  1  memory request strobe
- imem_addr  out  WORD_LEN  request address
- imem_rvalid  in  1  response valid
- imem_rdata  in  WORD_LEN  response instruction
- inst_valid  out  1  queue head valid
- inst  out  WORD_LEN  head instruction; 0 when empty
- inst_pc  out  WORD_LEN  head PC; 0 when empty
- fetch_fault  out  1  misaligned redirect trap (see Configuration)

## Operation
- Redirect: br_taken → target = br_pc + (br_offset << OFFSET_SHIFT); else jump_en → target = jump_addr << OFFSET_SHIFT. Both high: branch wins. Arithmetic modulo 2^WORD_LEN.
- Redirect edge: fetch_pc ← target, queue emptied, outstanding request marked stale; no request issued in the redirect cycle.
- States: IDLE (nothing outstanding), WAIT (one live request outstanding), DISCARD (one stale request outstanding). At most one request outstanding.
- IDLE: imem_req = 1 when (count + 0) < QUEUE_DEPTH and no redirect and not faulted; imem_addr = fetch_pc; edge: fetch_pc += PC_STEP, → WAIT.
- WAIT: imem_rvalid → push {fetch address, imem_rdata}, → IDLE; redirect without rvalid → DISCARD; redirect with rvalid → data dropped, → IDLE.
- DISCARD: imem_rvalid → data dropped, → IDLE; further redirects only update fetch_pc.
- Pop: inst_valid && !freeze at edge removes head. Simultaneous push and pop legal at any occupancy; overflow impossible because a request is only issued with a free slot reserved.
- Reset (any time, including mid-request): state IDLE, fetch_pc = RESET_PC, queue empty, outputs inst_valid/inst/inst_pc/fetch_fault = 0; imem_req = 0 while rst high. A response arriving after reset release for a pre-reset request is the environment's responsibility (memory is reset with the core).

## Timing
- imem_req/imem_addr combinational from registered state; imem_rvalid no earlier than the cycle after the request (memory latency L ≥ 1).
- Sequential fetch: request at cycle t, rvalid at t+L, inst_valid at t+L+1.
- Redirect at cycle t: request at t+1, inst_valid for target at t+L+2 (L=1: 3 cycles).
- Freeze holds inst/inst_pc/inst_valid stable; fetching continues until queue full.
- Flush clears inst_valid on the edge ending the redirect cycle.

## Configuration
- IF_MISALIGN_TRAP_EN defined: redirect target with nonzero low log2(PC_STEP) bits sets sticky fetch_fault on that edge, queue flushed, no further requests until reset.
- Undefined: low log2(PC_STEP) bits of target forced to 0; fetch_fault tied 0.

## Structure
- Shared package if_pkg: state enum (IDLE/WAIT/DISCARD), queue entry struct {pc, inst}, default constants for PC_STEP and OFFSET_SHIFT.
- One sub-module: if_prefetch_queue (synchronous FIFO with push, pop, flush, count, head outputs).

## Test plan
- Reset release, L=1, freeze=0: requests at 0,4,8,…; inst_pc sequence 0,4,8 with inst_valid from cycle 2.
- freeze held 10 cycles, L=1: exactly 4 entries accumulate, imem_req drops, head stays PC 0; release → pops in order, no loss.
- br_taken with br_pc=0x10, br_offset=0x8 while request to 0x14 outstanding (L=3): 0x14 response dropped, next inst_pc=0x20.
- br_taken and jump_en same cycle (jump_addr=0x40): branch target used, 0x80 never requested.
- Redirect to 0x22 with macro: fetch_fault=1, imem_req stays 0; without macro: fetch from 0x20.
- rst asserted during WAIT: all outputs 0 immediately; after release first request to RESET_PC.
